// File: rtl/port_array_deserializer.sv
// Purpose: assemble nports serial nbits elements into one flattened port array on a val/rdy output.
// Latency: out_val rises the cycle after the last element is accepted; back-to-back arrays are bubble-free.
// Backpressure: while a full array waits, in_rdy follows out_rdy combinationally, so the input stalls with the output.
module port_array_deserializer #(
    parameter int nports = 2,
    parameter int nbits  = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [nbits-1:0]          in_msg,
    input  logic                      in_val,
    output logic                      in_rdy,
    output logic [nports*nbits-1:0]   out_msg,
    output logic                      out_val,
    input  logic                      out_rdy
);

    localparam int            iw       = (nports > 1) ? $clog2(nports) : 1;
    localparam logic [iw-1:0] last_idx = iw'(nports - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [iw-1:0]             idx;
    logic [nports*nbits-1:0]   slots;
    logic                      in_fire;
    logic                      out_fire;
    logic                      last;

    assign in_fire  = in_val & in_rdy;
    assign out_fire = out_val & out_rdy;
    // idx is always 0 in FULL, so an input accepted in FULL naturally lands in slot 0.
    assign last     = (idx == last_idx);
    assign out_msg  = slots;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: FULL once the last slot is written; leave FULL on out fire unless a new array completes in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (in_fire && last) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_nxt = (in_fire && last) ? FULL : FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Outputs: always ready while filling; while full, accept only when the held array leaves.
    always_comb begin
        in_rdy  = 1'b1;
        out_val = 1'b0;
        if (state == FULL) begin
            in_rdy  = out_rdy;
            out_val = 1'b1;
        end
    end

    // Element counter, wraps to 0 after the last slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx <= '0;
        end else if (in_fire) begin
            idx <= last ? '0 : idx + iw'(1);
        end
    end

    // Slot storage; untouched slots keep stale data, hidden because out_val is low in FILL.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slots <= '0;
        end else begin
            for (int i = 0; i < nports; i++) begin
                if (in_fire && (idx == iw'(i))) begin
                    slots[i*nbits +: nbits] <= in_msg;
                end
            end
        end
    end

endmodule
